upsp_stream_gather: RTL and testbench

Parametrised output gatherer between N_LANES bicubic upsampling lanes and the AXI-Stream master port of the access-control path. Accepts one group of N_LANES pixels per handshake, buffers groups in a FIFO, and serialises them one pixel per beat in lane order. Generates AXI-Stream framing: tuser on the first pixel of a frame, tlast on the last pixel of each destination row. Replaces the single-lane direct write path with an N-lane gather that has flow-control decoupling and frame tracking.

---
 rtl/upsp_stream_gather.sv | 127 ++++++++++++
 tb/tb_upsp_stream_gather.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsp_stream_gather.sv
// N-lane pixel gatherer: buffers groups of N_LANES pixels in a FIFO and
// serialises them in lane order onto an AXI-Stream master with frame framing.
module upsp_stream_gather #(
    parameter int N_LANES        = 4,
    parameter int PIX_WIDTH      = 24,
    parameter int DST_IMG_WIDTH  = 3840,
    parameter int DST_IMG_HEIGHT = 2160,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           upsp_ac_wvalid,
    input  logic [N_LANES*PIX_WIDTH-1:0]   upsp_ac_wdata,
    output logic                           ac_upsp_wready,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [PIX_WIDTH-1:0]           m_axis_tdata,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic                           frame_done,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam int GW     = N_LANES * PIX_WIDTH;
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int COL_W  = (DST_IMG_WIDTH > 1) ? $clog2(DST_IMG_WIDTH) : 1;
    localparam int ROW_W  = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; a valid source holds its data until that edge.
    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state, state_nxt;
    logic [GW-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr, level;
    logic               ready_en;
    logic [LANE_W-1:0]  lane_idx;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               frame_done_q;
    logic [GW-1:0]      head;
    logic               full, push, pop, beat, last_lane, col_end, row_end;

    assign full           = (level == PW'(FIFO_DEPTH));
    assign ac_upsp_wready = ready_en && !full;
    assign m_axis_tvalid  = (state == STREAM);
    assign beat           = m_axis_tvalid && m_axis_tready;
    assign last_lane      = (lane_idx == LANE_W'(N_LANES - 1));
    assign col_end        = (col == COL_W'(DST_IMG_WIDTH - 1));
    assign row_end        = (row == ROW_W'(DST_IMG_HEIGHT - 1));
    // Clear wins over both sides of the FIFO.
    assign push           = upsp_ac_wvalid && ac_upsp_wready && !clear;
    assign pop            = beat && last_lane && !clear;

    assign head         = mem[rd_ptr[AW-1:0]];
    assign m_axis_tdata = m_axis_tvalid ? head[lane_idx*PIX_WIDTH +: PIX_WIDTH] : '0;
    assign m_axis_tlast = m_axis_tvalid && col_end;
    assign m_axis_tuser = m_axis_tvalid && (col == '0) && (row == '0);
    assign frame_done   = frame_done_q;
    assign fifo_level   = level;

    // Entering STREAM on the push edge gives lane 0 the cycle after acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push || level != '0) state_nxt = STREAM;
            STREAM:  if (pop && level == PW'(1) && !push) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= upsp_ac_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            lane_idx     <= '0;
            col          <= '0;
            row          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (clear) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level        <= '0;
                lane_idx     <= '0;
                col          <= '0;
                row          <= '0;
                frame_done_q <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   level <= level + PW'(1);
                    2'b01:   level <= level - PW'(1);
                    default: level <= level;
                endcase
                if (beat) begin
                    lane_idx <= last_lane ? '0 : lane_idx + LANE_W'(1);
                    if (col_end) begin
                        col <= '0;
                        row <= row_end ? '0 : row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                frame_done_q <= beat && col_end && row_end;
            end
        end
    end

endmodule

// File: tb/tb_upsp_stream_gather.sv
// Directed bench for upsp_stream_gather: 4 lanes, 8x2 frame, 4-deep FIFO.
module tb_upsp_stream_gather;

    localparam int NL = 4;
    localparam int PWD = 24;
    localparam int W = 8;
    localparam int H = 2;
    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            upsp_ac_wvalid = 1'b0;
    logic [NL*PWD-1:0] upsp_ac_wdata = '0;
    logic            ac_upsp_wready;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [PWD-1:0]  m_axis_tdata;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic            frame_done;
    logic [2:0]      fifo_level;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [PWD-1:0] beat_data[$];
    bit             beat_last[$];
    bit             beat_user[$];
    int             beat_cyc[$];
    int             done_cyc[$];

    upsp_stream_gather #(
        .N_LANES(NL), .PIX_WIDTH(PWD), .DST_IMG_WIDTH(W),
        .DST_IMG_HEIGHT(H), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .upsp_ac_wvalid(upsp_ac_wvalid), .upsp_ac_wdata(upsp_ac_wdata),
        .ac_upsp_wready(ac_upsp_wready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .frame_done(frame_done),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a beat seen valid/ready here transfers on the next edge.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            beat_data.push_back(m_axis_tdata);
            beat_last.push_back(m_axis_tlast);
            beat_user.push_back(m_axis_tuser);
            beat_cyc.push_back(cyc);
        end
        if (rst_n && frame_done) done_cyc.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_queues();
        beat_data.delete(); beat_last.delete(); beat_user.delete();
        beat_cyc.delete(); done_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; upsp_ac_wvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_queues();
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_group(input int base, output bit ok, output int acc_cyc);
        for (int k = 0; k < NL; k++) upsp_ac_wdata[k*PWD +: PWD] = PWD'(base + k);
        upsp_ac_wvalid = 1'b1;
        ok = 1'b0;
        acc_cyc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ac_upsp_wready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        upsp_ac_wvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, output bit ok);
        for (int t = 0; t < 300 && beat_data.size() < n; t++) @(posedge clk);
        #1;
        ok = (beat_data.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; upsp_ac_wvalid = 1'b0; m_axis_tready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++; if (ac_upsp_wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready: got %b expected 0", ac_upsp_wready); end
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        n_checks++; if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
        n_checks++; if ({m_axis_tlast, m_axis_tuser, frame_done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {m_axis_tlast, m_axis_tuser, frame_done}); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (ac_upsp_wready !== 1'b1) begin n_fail++; $display("FAIL release_wready: got %b expected 1", ac_upsp_wready); end
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL release_tvalid: got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_single_frame();
        bit ok; int acc0, acc;
        do_reset();
        m_axis_tready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            push_group(4*g, ok, acc);
            if (g == 0) acc0 = acc;
            n_checks++; if (!ok) begin n_fail++; $display("FAIL single_push%0d: got timeout expected accept", g); end
        end
        wait_beats(16, ok);
        repeat (4) @(posedge clk); #1;
        n_checks++; if (beat_data.size() != 16) begin n_fail++; $display("FAIL single_count: got %0d expected 16", beat_data.size()); end
        if (beat_data.size() >= 16) begin
            n_checks++; if (beat_cyc[0] != acc0 + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", beat_cyc[0] - acc0, 1); end
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (beat_data[i] !== PWD'(i)) begin n_fail++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, beat_data[i], i); end
                n_checks++; if (beat_last[i] !== (i == 7 || i == 15)) begin n_fail++; $display("FAIL single_tlast[%0d]: got %b expected %b", i, beat_last[i], (i == 7 || i == 15)); end
                n_checks++; if (beat_user[i] !== (i == 0)) begin n_fail++; $display("FAIL single_tuser[%0d]: got %b expected %b", i, beat_user[i], (i == 0)); end
                n_checks++; if (beat_cyc[i] != beat_cyc[0] + i) begin n_fail++; $display("FAIL single_gap[%0d]: got cycle %0d expected %0d", i, beat_cyc[i], beat_cyc[0] + i); end
            end
            n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_cyc.size()); end
            else begin
                n_checks++; if (done_cyc[0] != beat_cyc[15] + 1) begin n_fail++; $display("FAIL single_done_time: got %0d expected %0d", done_cyc[0], beat_cyc[15] + 1); end
            end
        end
        n_checks++; if (fifo_level !== 3'd0 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got level %0d tvalid %b expected 0 0", fifo_level, m_axis_tvalid); end
    endtask

    task automatic test_full_fifo();
        bit ok; int acc;
        do_reset();
        for (int g = 0; g < 4; g++) begin
            push_group(4*g, ok, acc);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL full_push%0d: got timeout expected accept", g); end
        end
        for (int k = 0; k < NL; k++) upsp_ac_wdata[k*PWD +: PWD] = PWD'(16 + k);
        upsp_ac_wvalid = 1'b1;
        @(negedge clk);
        n_checks++; if (ac_upsp_wready !== 1'b0) begin n_fail++; $display("FAIL full_wready: got %b expected 0", ac_upsp_wready); end
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d expected 4", fifo_level); end
        n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'd0) begin n_fail++; $display("FAIL full_head: got tvalid %b tdata %0d expected 1 0", m_axis_tvalid, m_axis_tdata); end
        @(posedge clk); #1 m_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (ac_upsp_wready !== 1'b0) begin n_fail++; $display("FAIL full_wready_hold%0d: got %b expected 0", k, ac_upsp_wready); end
        end
        @(negedge clk);
        n_checks++; if (ac_upsp_wready !== 1'b1) begin n_fail++; $display("FAIL full_wready_return: got %b expected 1", ac_upsp_wready); end
        n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL full_level_after_pop: got %0d expected 3", fifo_level); end
        @(posedge clk); #1 upsp_ac_wvalid = 1'b0;
        wait_beats(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_count: got %0d expected 20", beat_data.size()); end
        else begin
            for (int i = 0; i < 20; i++) begin
                n_checks++; if (beat_data[i] !== PWD'(i)) begin n_fail++; $display("FAIL full_data[%0d]: got %0d expected %0d", i, beat_data[i], i); end
                n_checks++; if (beat_user[i] !== (i == 0 || i == 16)) begin n_fail++; $display("FAIL full_tuser[%0d]: got %b expected %b", i, beat_user[i], (i == 0 || i == 16)); end
                n_checks++; if (beat_last[i] !== (i == 7 || i == 15)) begin n_fail++; $display("FAIL full_tlast[%0d]: got %b expected %b", i, beat_last[i], (i == 7 || i == 15)); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int acc;
        logic [PWD-1:0] prev_data; logic prev_last, prev_user, stalled;
        do_reset();
        for (int g = 0; g < 4; g++) begin
            push_group(4*g, ok, acc);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_push%0d: got timeout expected accept", g); end
        end
        stalled = 1'b0; prev_data = '0; prev_last = 1'b0; prev_user = 1'b0;
        for (int t = 0; t < 80 && beat_data.size() < 16; t++) begin
            @(negedge clk);
            if (stalled) begin
                n_checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !== {1'b1, prev_data, prev_last, prev_user}) begin
                    n_fail++; $display("FAIL bp_stable: got %b %h %b %b expected 1 %h %b %b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, prev_data, prev_last, prev_user);
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata; prev_last = m_axis_tlast; prev_user = m_axis_tuser;
            @(posedge clk); #1 m_axis_tready = ~m_axis_tready;
        end
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (beat_data.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d expected 16", beat_data.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (beat_data[i] !== PWD'(i) || beat_last[i] !== (i == 7 || i == 15) || beat_user[i] !== (i == 0)) begin
                    n_fail++; $display("FAIL bp_beat[%0d]: got %0d/%b/%b expected %0d/%b/%b", i, beat_data[i], beat_last[i], beat_user[i], i, (i == 7 || i == 15), (i == 0));
                end
            end
        end
        n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cyc.size()); end
    endtask

    task automatic test_clear();
        bit ok; int acc;
        do_reset();
        m_axis_tready = 1'b1;
        for (int g = 0; g < 4; g++) push_group(4*g, ok, acc);
        for (int t = 0; t < 50 && beat_data.size() < 6; t++) @(posedge clk);
        #1;
        n_checks++; if (beat_data.size() != 6) begin n_fail++; $display("FAIL clr_reach_beat5: got %0d beats expected 6", beat_data.size()); end
        clear = 1'b1;
        for (int k = 0; k < NL; k++) upsp_ac_wdata[k*PWD +: PWD] = PWD'(24'h200 + k);
        upsp_ac_wvalid = 1'b1;
        @(posedge clk); #1 clear = 1'b0; upsp_ac_wvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL clr_tvalid: got %b expected 0", m_axis_tvalid); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL clr_level: got %0d expected 0", fifo_level); end
        n_checks++; if (ac_upsp_wready !== 1'b1) begin n_fail++; $display("FAIL clr_wready: got %b expected 1", ac_upsp_wready); end
        repeat (2) @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL clr_dropped_push: got tvalid %b level %0d expected 0 0", m_axis_tvalid, fifo_level); end
        n_checks++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL clr_no_done: got %0d pulses expected 0", done_cyc.size()); end
        @(posedge clk); #1;
        clear_queues();
        push_group(24'h300, ok, acc);
        wait_beats(4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clr_restart_count: got %0d expected 4", beat_data.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (beat_data[i] !== PWD'(24'h300 + i) || beat_user[i] !== (i == 0) || beat_last[i] !== 1'b0) begin
                    n_fail++; $display("FAIL clr_restart[%0d]: got %h/%b/%b expected %h/%b/0", i, beat_data[i], beat_user[i], beat_last[i], 24'h300 + i, (i == 0));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok; int acc;
        do_reset();
        m_axis_tready = 1'b1;
        for (int g = 0; g < 4; g++) push_group(4*g, ok, acc);
        for (int t = 0; t < 50 && beat_data.size() < 9; t++) @(posedge clk);
        #1;
        n_checks++; if (m_axis_tdata !== 24'd9) begin n_fail++; $display("FAIL arst_beat9: got %0d expected 9", m_axis_tdata); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done, ac_upsp_wready} !== 5'b0) begin n_fail++; $display("FAIL arst_flags: got %b expected 00000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done, ac_upsp_wready}); end
        n_checks++; if (m_axis_tdata !== '0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL arst_data_level: got %h/%0d expected 0/0", m_axis_tdata, fifo_level); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_queues();
        push_group(24'h400, ok, acc);
        push_group(24'h404, ok, acc);
        wait_beats(8, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL arst_count: got %0d expected 8", beat_data.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (beat_data[i] !== PWD'(24'h400 + i) || beat_user[i] !== (i == 0) || beat_last[i] !== (i == 7)) begin
                    n_fail++; $display("FAIL arst_restart[%0d]: got %h/%b/%b expected %h/%b/%b", i, beat_data[i], beat_user[i], beat_last[i], 24'h400 + i, (i == 0), (i == 7));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int acc;
        do_reset();
        m_axis_tready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            push_group(4*g, ok, acc);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_push%0d: got timeout expected accept", g); end
        end
        wait_beats(32, ok);
        repeat (3) @(posedge clk); #1;
        n_checks++; if (beat_data.size() != 32) begin n_fail++; $display("FAIL b2b_count: got %0d expected 32", beat_data.size()); end
        else begin
            for (int i = 0; i < 32; i++) begin
                n_checks++; if (beat_data[i] !== PWD'(i) || beat_cyc[i] != beat_cyc[0] + i) begin
                    n_fail++; $display("FAIL b2b_beat[%0d]: got %0d at cycle %0d expected %0d at cycle %0d", i, beat_data[i], beat_cyc[i], i, beat_cyc[0] + i);
                end
                n_checks++; if (beat_user[i] !== (i == 0 || i == 16) || beat_last[i] !== (i % 8 == 7)) begin
                    n_fail++; $display("FAIL b2b_flags[%0d]: got %b/%b expected %b/%b", i, beat_user[i], beat_last[i], (i == 0 || i == 16), (i % 8 == 7));
                end
            end
            n_checks++; if (done_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cyc.size()); end
            else begin
                n_checks++; if (done_cyc[0] != beat_cyc[15] + 1 || done_cyc[1] != beat_cyc[31] + 1) begin
                    n_fail++; $display("FAIL b2b_done_time: got %0d,%0d expected %0d,%0d", done_cyc[0], done_cyc[1], beat_cyc[15] + 1, beat_cyc[31] + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_full_fifo();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
